// File: rtl/mask_writeback_collector.sv
// Write-out collector for the convolutional unit: stores each {harris, pixel} beat into
// an N*N result RAM, counts beats and corners, flags protocol errors, serves host reads.
module mask_writeback_collector #(
  parameter int N          = 8,
  parameter int bitSize    = 6,
  parameter int pixelWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_wr_en,
  input  logic [bitSize:0]      in_addr,
  input  logic [pixelWidth-1:0] in_pixel,
  input  logic                  in_harris,
  input  logic                  clear,
  input  logic [bitSize:0]      rd_addr,
  output logic [pixelWidth-1:0] rd_pixel,
  output logic                  rd_harris,
  output logic                  busy,
  output logic                  frame_ready,
  output logic                  frame_done,
  output logic [bitSize+1:0]    beat_count,
  output logic [bitSize+1:0]    harris_count,
  output logic                  seq_err,
  output logic                  overrun_err
);

  localparam int AW    = bitSize + 1;
  localparam int CW    = bitSize + 2;
  localparam int DEPTH = N * N;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic [1:0] S_DRAIN   = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [AW-1:0]       last_addr;
  logic [pixelWidth:0] mem [0:DEPTH-1];

  logic first_beat;
  logic take;
  logic in_range;
  logic rd_in_range;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val, input logic inc);
    if (inc && (val != {CW{1'b1}}))
      return val + 1'b1;
    return val;
  endfunction

  // The producer holds each address for two clocks; only an address change is a new beat.
  always_comb begin
    first_beat  = (state == S_IDLE);
    take        = in_wr_en && !clear &&
                  (first_beat || ((state == S_COLLECT) && (in_addr != last_addr)));
    in_range    = ({1'b0, in_addr} < DEPTH_C);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_DRAIN:   if (!in_wr_en) state_nxt = S_IDLE;
      S_IDLE:    if (in_wr_en && !clear) state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (clear)          state_nxt = S_DRAIN;
        else if (!in_wr_en) state_nxt = S_DONE;
      end
      default: begin
        if (clear) state_nxt = in_wr_en ? S_DRAIN : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_DRAIN;
      last_addr    <= '0;
      beat_count   <= '0;
      harris_count <= '0;
      seq_err      <= 1'b0;
      overrun_err  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == S_COLLECT) && !clear && !in_wr_en;
      if (clear) begin
        beat_count   <= '0;
        harris_count <= '0;
        seq_err      <= 1'b0;
        overrun_err  <= 1'b0;
      end else begin
        if (take) begin
          last_addr <= in_addr;
          if (first_beat) begin
            beat_count   <= CW'(in_range);
            harris_count <= CW'(in_range && in_harris);
          end else begin
            beat_count   <= sat_inc(beat_count, in_range);
            harris_count <= sat_inc(harris_count, in_range && in_harris);
          end
          if (!in_range || (!first_beat && (in_addr < last_addr)))
            seq_err <= 1'b1;
        end
        if ((state == S_DONE) && in_wr_en)
          overrun_err <= 1'b1;
      end
    end
  end

  // Result RAM: not reset, write port from the beat stream.
  always_ff @(posedge clk) begin
    if (take && in_range)
      mem[in_addr[IW-1:0]] <= {in_harris, in_pixel};
  end

  // Registered host read; a same-cycle write is seen on the following read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pixel  <= '0;
      rd_harris <= 1'b0;
    end else if (rd_in_range) begin
      {rd_harris, rd_pixel} <= mem[rd_addr[IW-1:0]];
    end else begin
      rd_pixel  <= '0;
      rd_harris <= 1'b0;
    end
  end

  assign busy        = (state == S_COLLECT);
  assign frame_ready = (state == S_DONE);

endmodule

// File: tb/tb_mask_writeback_collector.sv
// Bench for mask_writeback_collector: frame collection, error flags, clear/reset corners,
// host reads checked through a queue of expected read data.
module tb_mask_writeback_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_wr_en;
  logic [6:0] in_addr;
  logic [7:0] in_pixel;
  logic       in_harris;
  logic       clear;
  logic [6:0] rd_addr;
  logic [7:0] rd_pixel;
  logic       rd_harris;
  logic       busy;
  logic       frame_ready;
  logic       frame_done;
  logic [7:0] beat_count;
  logic [7:0] harris_count;
  logic       seq_err;
  logic       overrun_err;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  typedef struct {
    int addr;
    int pix;
    int har;
  } rd_vec_t;

  rd_vec_t    tab[7];
  logic [8:0] exp_q[$];

  mask_writeback_collector #(.N(8), .bitSize(6), .pixelWidth(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_wr_en(in_wr_en), .in_addr(in_addr),
    .in_pixel(in_pixel), .in_harris(in_harris), .clear(clear), .rd_addr(rd_addr),
    .rd_pixel(rd_pixel), .rd_harris(rd_harris), .busy(busy), .frame_ready(frame_ready),
    .frame_done(frame_done), .beat_count(beat_count), .harris_count(harris_count),
    .seq_err(seq_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) pulses++;
  endtask

  task automatic drive_addr(input int a, input int off);
    in_wr_en  = 1'b1;
    in_addr   = 7'(a);
    in_pixel  = 8'(a + off);
    in_harris = (a % 8 == 0);
    tick();
    tick();
  endtask

  task automatic end_frame();
    in_wr_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic rd_chk(input string name, input int a, input int p, input int h);
    logic [8:0] exp;
    rd_addr = 7'(a);
    exp_q.push_back({h[0], p[7:0]});
    tick();
    exp = exp_q.pop_front();
    chk(name, int'({rd_harris, rd_pixel}), int'(exp));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    tab[0] = '{9, 9, 0};
    tab[1] = '{0, 0, 1};
    tab[2] = '{63, 63, 0};
    tab[3] = '{8, 8, 1};
    tab[4] = '{70, 0, 0};
    tab[5] = '{64, 0, 0};
    tab[6] = '{16, 16, 1};

    rst_n = 1'b0; in_wr_en = 1'b0; in_addr = '0; in_pixel = '0; in_harris = 1'b0;
    clear = 1'b0; rd_addr = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", frame_ready, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_beats", beat_count, 0);
    chk("rst_harris", harris_count, 0);
    chk("rst_errs", {seq_err, overrun_err}, 0);
    chk("rst_rd", {rd_harris, rd_pixel}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Normal frame
    pulses = 0;
    drive_addr(0, 0);
    chk("busy_first", busy, 1);
    for (int a = 1; a < 64; a++) drive_addr(a, 0);
    end_frame();
    chk("a_beats", beat_count, 64);
    chk("a_harris", harris_count, 8);
    chk("a_pulses", pulses, 1);
    chk("a_ready", frame_ready, 1);
    chk("a_seq", seq_err, 0);
    for (int i = 0; i < 7; i++)
      rd_chk($sformatf("rd_tab%0d", i), tab[i].addr, tab[i].pix, tab[i].har);

    // Second frame without clear
    pulses = 0;
    for (int a = 0; a < 64; a++) drive_addr(a, 100);
    end_frame();
    chk("ovr_err", overrun_err, 1);
    chk("ovr_ready", frame_ready, 1);
    chk("ovr_beats", beat_count, 64);
    chk("ovr_pulses", pulses, 0);
    rd_chk("ovr_rd9", 9, 9, 0);
    rd_chk("ovr_rd40", 40, 40, 1);
    do_clear();
    tick();
    chk("clr_beats", beat_count, 0);
    chk("clr_harris", harris_count, 0);
    chk("clr_errs", {seq_err, overrun_err}, 0);
    chk("clr_ready", frame_ready, 0);

    // Descending address 20 then 19
    for (int a = 0; a < 64; a++) begin
      if (a == 19) drive_addr(20, 0);
      else if (a == 20) drive_addr(19, 0);
      else drive_addr(a, 0);
    end
    end_frame();
    chk("desc_seq", seq_err, 1);
    chk("desc_beats", beat_count, 64);
    do_clear();

    // Out-of-range address 70 injected
    for (int a = 0; a < 64; a++) begin
      drive_addr(a, 0);
      if (a == 30) drive_addr(70, 0);
    end
    end_frame();
    chk("oor_seq", seq_err, 1);
    chk("oor_beats", beat_count, 64);
    chk("oor_harris", harris_count, 8);
    rd_chk("oor_rd30", 30, 30, 0);
    rd_chk("oor_rd31", 31, 31, 0);
    rd_chk("oor_rd6", 6, 6, 0);
    do_clear();

    // Clear at beat 30
    pulses = 0;
    for (int a = 0; a < 30; a++) drive_addr(a, 50);
    in_addr = 7'd30; in_pixel = 8'd80; in_harris = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_beats", beat_count, 0);
    for (int a = 30; a < 64; a++) drive_addr(a, 50);
    chk("abort_drain_beats", beat_count, 0);
    end_frame();
    chk("abort_pulses", pulses, 0);
    chk("abort_ready", frame_ready, 0);

    // Reset mid-frame, released with in_wr_en still high
    pulses = 0;
    for (int a = 0; a < 20; a++) drive_addr(a, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_beats", beat_count, 0);
    tick();
    rst_n = 1'b1;
    for (int a = 20; a < 64; a++) drive_addr(a, 0);
    chk("mrst_beats_after", beat_count, 0);
    end_frame();
    chk("mrst_pulses", pulses, 0);
    chk("mrst_ready", frame_ready, 0);
    pulses = 0;
    for (int a = 0; a < 64; a++) drive_addr(a, 0);
    end_frame();
    chk("full_beats", beat_count, 64);
    chk("full_harris", harris_count, 8);
    chk("full_pulses", pulses, 1);
    rd_chk("full_rd5", 5, 5, 0);
    rd_chk("full_rd24", 24, 24, 1);

    // Clear and a new frame start in the same DONE cycle
    pulses = 0;
    in_wr_en = 1'b1; in_addr = '0; in_pixel = 8'd100; in_harris = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cs_ready", frame_ready, 0);
    chk("cs_busy", busy, 0);
    chk("cs_beats", beat_count, 0);
    chk("cs_ovr", overrun_err, 0);
    for (int a = 0; a < 64; a++) drive_addr(a, 100);
    end_frame();
    chk("cs_beats_end", beat_count, 0);
    chk("cs_ovr_end", overrun_err, 0);
    chk("cs_pulses", pulses, 0);
    rd_chk("cs_rd9", 9, 9, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mask_writeback_collector.md
Name: mask_writeback_collector

Overview:
- Receiving end of the convolutional unit's write-out stream: consumes the enable/address/pixel/Harris-bit interface and stores each beat into an N*N result RAM.
- Reports frame completion, beat count, Harris-corner count and protocol errors.
- Provides a registered host read port for the finished frame.
- Tolerates the producer's two-clock-per-beat cadence: each address is held for 2 cycles and must be counted once.

Parameters:
- N, 8, image side length; frame = N*N pixels
- bitSize, 6, address MSB index; address width is bitSize+1
- pixelWidth, 8, pixel bit width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_wr_en  input  1  producer write-out enable; high for the whole frame window
- in_addr  input  bitSize+1  producer pixel address
- in_pixel  input  pixelWidth  producer pixel value
- in_harris  input  1  producer Harris-corner bit for this pixel
- clear  input  1  host acknowledge/abort; clears counters and errors
- rd_addr  input  bitSize+1  host read address
- rd_pixel  output  pixelWidth  stored pixel at rd_addr, 1-cycle latency
- rd_harris  output  1  stored Harris bit at rd_addr, 1-cycle latency
- busy  output  1  high in COLLECT
- frame_ready  output  1  high in DONE
- frame_done  output  1  one-cycle pulse on COLLECT->DONE
- beat_count  output  bitSize+2  beats accepted in current/last frame
- harris_count  output  bitSize+2  accepted beats with in_harris=1
- seq_err  output  1  sticky: out-of-range or descending address seen
- overrun_err  output  1  sticky: new frame started while DONE not cleared

Behaviour:
- Reset (async, rst_n=0):
  - state=DRAIN; all outputs 0; last_addr=0.
  - RAM contents are not reset; reads before the first frame are undefined.
- States: DRAIN, IDLE, COLLECT, DONE. State is registered; outputs are registered from state and counters.
- DRAIN:
  - Ignores input beats.
  - in_wr_en=0 -> IDLE.
  - Discards any frame already in progress at reset release or abort.
- IDLE:
  - in_wr_en=1 -> COLLECT. That same cycle is the first beat and is accepted unconditionally.
  - On entry to COLLECT from IDLE: beat_count and harris_count restart from 0.
- Beat acceptance (IDLE->COLLECT edge or COLLECT):
  - Accept when in_wr_en=1 and (first beat of frame, or in_addr != last_addr).
  - Repeated address on consecutive cycles = same beat: no write, no count.
- Accepted beat with in_addr < N*N:
  - RAM[in_addr] <= {in_harris, in_pixel}; beat_count++; harris_count += in_harris; last_addr <= in_addr.
  - If not the first beat and in_addr < last_addr: seq_err <= 1. The beat is still written and counted.
- Accepted beat with in_addr >= N*N:
  - No write, no count, seq_err <= 1; last_addr <= in_addr.
- Counters saturate at 2^(bitSize+2)-1. They cannot reach saturation with a legal frame.
- COLLECT:
  - in_wr_en=0 -> DONE; frame_done=1 for exactly the first DONE cycle.
  - clear=1 -> DRAIN; counters and errors zeroed; rest of the window ignored.
- DONE:
  - Holds counters and RAM.
  - clear=1 -> counters and errors zeroed; next state IDLE if in_wr_en=0, else DRAIN. Clear wins over a simultaneous frame start.
  - in_wr_en rising without clear -> overrun_err <= 1; stay DONE; beats dropped; RAM unchanged.
- clear in IDLE/DRAIN: zeroes counters and errors, no state change.
- Host read:
  - rd_pixel/rd_harris <= RAM[rd_addr] every cycle, in any state.
  - rd_addr >= N*N returns 0.
  - Read of an address written in the same cycle returns the old data.
- Beat acceptance registers in_* in the accepting cycle: no input stall and no backpressure. The producer is never throttled.

Test Plan:
- Reset, then in_wr_en high 128 cycles, addresses 0..63 each held 2 cycles, pixel=addr, harris=1 on addr%8==0 -> beat_count=64, harris_count=8, frame_done one pulse, rd_addr=9 gives rd_pixel=9 next cycle, seq_err=0.
- Same frame with address 20 followed by 19 -> seq_err=1, beat_count=64. With address 70 injected -> seq_err=1, beat_count excludes it, RAM at 0..63 unaffected.
- After DONE, start a second frame without clear -> overrun_err=1, frame_ready stays 1, RAM still holds the first frame. Then clear with in_wr_en low -> IDLE, counters 0, errors 0.
- clear asserted mid-COLLECT at beat 30 -> busy drops next cycle, DRAIN until in_wr_en low, no frame_done, beat_count=0.
- rst_n pulsed low mid-frame, released while in_wr_en still high -> all outputs 0 immediately, rest of the frame ignored. The next full frame is collected normally with beat_count=64.
- clear and a new in_wr_en rising in the same DONE cycle -> counters cleared, state DRAIN, overrun_err stays 0, that frame is not collected.
